// File: rtl/argmax_stream_if.sv
// Valid/ready sample stream in, valid/ready {index, max} result out.
// The slave view belongs to the argmax controller; the master view is the
// environment that produces samples and consumes results.
interface argmax_stream_if #(
  parameter int W  = 8,
  parameter int IW = 4
);
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [IW-1:0] m_index;
  logic [W-1:0]  m_max;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_index, m_max
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_index, m_max
  );
endinterface

// File: rtl/argmax_stream_ctrl.sv
// Serial argmax over frames of N unsigned samples, one comparator.
// The first sample of a frame seeds the running maximum; each later sample
// replaces it only when strictly greater, so ties keep the lowest index.
// The result register is loaded on the edge that accepts the last sample and
// is held until the consumer takes it.
module argmax_stream_ctrl #(
  parameter int N  = 10,
  parameter int W  = 8,
  parameter int IW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  output logic            busy,
  argmax_stream_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [1:0]    state_reg;
  logic [IW-1:0] cnt_reg;
  logic [IW-1:0] run_idx_reg;
  logic [W-1:0]  run_max_reg;
  logic [IW-1:0] m_index_reg;
  logic [W-1:0]  m_max_reg;

  logic          s_accept;
  logic          new_max;

  assign bus.s_ready = (state_reg != ST_DONE);
  assign bus.m_valid = (state_reg == ST_DONE);
  assign busy        = (state_reg == ST_ACCUM);
  assign bus.m_index = m_index_reg;
  assign bus.m_max   = m_max_reg;

  assign s_accept = bus.s_valid && bus.s_ready;
  assign new_max  = (bus.s_data > run_max_reg);

  // Frame sequencer: seed, accumulate running max/index, publish result, wait for take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      run_idx_reg <= '0;
      run_max_reg <= '0;
      m_index_reg <= '0;
      m_max_reg   <= '0;
    end else if (clear) begin
      // Abort wins over any handshake in the same cycle; the last result stays visible.
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      run_idx_reg <= '0;
      run_max_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s_accept) begin
            run_max_reg <= bus.s_data;
            run_idx_reg <= '0;
            cnt_reg     <= IW'(1);
            state_reg   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (s_accept) begin
            if (new_max) begin
              run_max_reg <= bus.s_data;
              run_idx_reg <= cnt_reg;
            end
            if (cnt_reg == LAST_IDX) begin
              // Last sample: fold it straight into the result; cnt stays at N-1.
              m_max_reg   <= new_max ? bus.s_data : run_max_reg;
              m_index_reg <= new_max ? cnt_reg : run_idx_reg;
              state_reg   <= ST_DONE;
            end else begin
              cnt_reg <= cnt_reg + IW'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.m_ready) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Self-checking bench for argmax_stream_ctrl: directed frames plus random
// frames compared against a simple argmax reference model.
module tb_argmax_stream_ctrl;

  localparam int N  = 10;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int NF = 100;

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;

  argmax_stream_if #(.W(W), .IW(IW)) bus ();

  argmax_stream_ctrl #(.N(N), .W(W), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] cur_frame [N];
  logic [W-1:0] samples [N*NF];
  logic [IW-1:0] exp_idx [NF];
  logic [W-1:0]  exp_max [NF];

  // Reference: find the largest value, then the first position holding it.
  task automatic ref_argmax(output logic [IW-1:0] ei, output logic [W-1:0] em);
    int best;
    best = 0;
    for (int i = 0; i < N; i++)
      if (int'(cur_frame[i]) > best) best = int'(cur_frame[i]);
    em = W'(best);
    ei = '0;
    for (int i = N - 1; i >= 0; i--)
      if (int'(cur_frame[i]) == best) ei = IW'(i);
  endtask

  // Push the first n samples of cur_frame, with random s_valid gaps; returns
  // at the falling edge just after the edge that accepted the n-th sample.
  task automatic send_frame(input int n, input int gap_pct);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.s_valid = 1'b0;
        bus.s_data  = W'($urandom);
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = cur_frame[i];
        if (bus.s_ready) i++;
      end
    end
    if (i < n) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: accepted %0d samples, required %0d", i, n);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [IW-1:0] ei, input logic [W-1:0] em);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid: m_valid=%b required 1", name, bus.m_valid);
    end
    checks++;
    if (bus.m_index !== ei || bus.m_max !== em) begin
      failures++;
      $display("FAIL %s_result: index=%0d max=%0d required index=%0d max=%0d",
               name, bus.m_index, bus.m_max, ei, em);
    end
    $display("%s result index=%0d max=%0d", name, bus.m_index, bus.m_max);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #2;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || busy !== 1'b0 ||
        bus.m_index !== '0 || bus.m_max !== '0) begin
      failures++;
      $display("FAIL reset: s_ready=%b m_valid=%b busy=%b index=%0d max=%0d required 1 0 0 0 0",
               bus.s_ready, bus.m_valid, busy, bus.m_index, bus.m_max);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: s_ready=%b m_valid=%b busy=%b required 1 0 0",
               bus.s_ready, bus.m_valid, busy);
    end
    $display("reset done");
  endtask

  task automatic test_basic();
    logic [W-1:0] vals [N] = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd4, 8'd8, 8'd5};
    bus.m_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_frame[i] = vals[i];
    send_frame(N - 1, 0);
    checks++;
    if (busy !== 1'b1 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_midframe: busy=%b m_valid=%b required 1 0", busy, bus.m_valid);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = cur_frame[N-1];
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_result("basic", 4'd3, 8'd9);
    checks++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: busy=%b s_ready=%b required 0 0", busy, bus.s_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_max !== 8'd9 || bus.m_index !== 4'd3) begin
      failures++;
      $display("FAIL basic_after: m_valid=%b index=%0d max=%0d required 0 3 9",
               bus.m_valid, bus.m_index, bus.m_max);
    end
  endtask

  task automatic test_ties_and_last();
    bus.m_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_frame[i] = 8'h55;
    send_frame(N, 0);
    check_result("all_equal", 4'd0, 8'h55);
    @(negedge clk);
    for (int i = 0; i < N; i++) cur_frame[i] = (i < N - 1) ? W'(i) : 8'd255;
    send_frame(N, 0);
    check_result("last_max", 4'd9, 8'd255);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] ei;
    logic [W-1:0]  em;
    bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) cur_frame[i] = W'($urandom);
    ref_argmax(ei, em);
    send_frame(N, 40);
    check_result("hold", ei, em);
    for (int c = 0; c < 5; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = W'($urandom);
      @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 ||
          bus.m_index !== ei || bus.m_max !== em) begin
        failures++;
        $display("FAIL hold_stable: cycle %0d s_ready=%b m_valid=%b index=%0d max=%0d required 0 1 %0d %0d",
                 c, bus.s_ready, bus.m_valid, bus.m_index, bus.m_max, ei, em);
      end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_take: m_valid=%b s_ready=%b required 0 1", bus.m_valid, bus.s_ready);
    end
    for (int i = 0; i < N; i++) cur_frame[i] = W'($urandom);
    ref_argmax(ei, em);
    send_frame(N, 40);
    check_result("after_hold", ei, em);
    @(negedge clk);
  endtask

  task automatic test_clear();
    bus.m_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_frame[i] = 8'd250;
    send_frame(4, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd200;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.s_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_idle: busy=%b m_valid=%b s_ready=%b required 0 0 1",
               busy, bus.m_valid, bus.s_ready);
    end
    for (int i = 0; i < N; i++) cur_frame[i] = W'(10 * (i + 1));
    send_frame(N, 0);
    check_result("after_clear", 4'd9, 8'd100);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [IW-1:0] ei;
    logic [W-1:0]  em;
    bus.m_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_frame[i] = W'($urandom);
    send_frame(5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || busy !== 1'b0 ||
        bus.m_index !== '0 || bus.m_max !== '0) begin
      failures++;
      $display("FAIL async_reset: s_ready=%b m_valid=%b busy=%b index=%0d max=%0d required 1 0 0 0 0",
               bus.s_ready, bus.m_valid, busy, bus.m_index, bus.m_max);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) cur_frame[i] = W'($urandom);
    ref_argmax(ei, em);
    send_frame(N, 20);
    check_result("after_reset", ei, em);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pos;
    int res;
    int cyc;
    int last_cyc;
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < N; i++) begin
        cur_frame[i] = (f % 4 == 0) ? W'($urandom_range(3)) : W'($urandom);
        samples[f*N + i] = cur_frame[i];
      end
      ref_argmax(exp_idx[f], exp_max[f]);
    end
    bus.m_ready = 1'b1;
    pos = 0;
    res = 0;
    cyc = 0;
    last_cyc = 0;
    while (res < NF && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (bus.m_valid === 1'b1) begin
        checks++;
        if (bus.m_index !== exp_idx[res] || bus.m_max !== exp_max[res]) begin
          failures++;
          $display("FAIL b2b_frame%0d: index=%0d max=%0d required index=%0d max=%0d",
                   res, bus.m_index, bus.m_max, exp_idx[res], exp_max[res]);
        end
        if (res > 0) begin
          checks++;
          if (cyc - last_cyc != N + 1) begin
            failures++;
            $display("FAIL b2b_period%0d: %0d cycles required %0d", res, cyc - last_cyc, N + 1);
          end
        end
        $display("b2b frame %0d index=%0d max=%0d", res, bus.m_index, bus.m_max);
        last_cyc = cyc;
        res++;
      end
      if (pos < N * NF) begin
        bus.s_valid = 1'b1;
        bus.s_data  = samples[pos];
        if (bus.s_ready) pos++;
      end else begin
        bus.s_valid = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    if (res < NF) begin
      checks++;
      failures++;
      $display("FAIL b2b_timeout: %0d results required %0d", res, NF);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_and_last();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
